// File: rtl/pulse_cdc_pkg.sv
// ============================================================================
//  Module   : pulse_cdc_pkg
//  Brief    : Shared types and constants for the pulse CDC request controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pulse_cdc_pkg;

    localparam int unsigned c_SYNC_STAGES_MIN = 2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Anything shallower than the minimum cannot resolve metastability.
    function automatic int unsigned clamp_stages(input int unsigned stages);
        return (stages < c_SYNC_STAGES_MIN) ? c_SYNC_STAGES_MIN : stages;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_cdc_ack_sync.sv
// ============================================================================
//  Module   : pulse_cdc_ack_sync
//  Brief    : Toggle-to-pulse synchroniser for the far-domain ack toggle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_cdc_ack_sync
    import pulse_cdc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ack_toggle,
    output logic o_ack_pulse
);

    localparam int unsigned c_STAGES = clamp_stages(SYNC_STAGES);

    // The extra flop beyond the synchroniser depth holds the previous level
    // so each toggle edge yields exactly one single-cycle pulse.
    (* syn_preserve = 1 *) logic [c_STAGES:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_STAGES-1:0], i_ack_toggle};
        end
    end

    assign o_ack_pulse = r_sync[c_STAGES] ^ r_sync[c_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pulse_cdc_req_ctrl.sv
// ============================================================================
//  Module   : pulse_cdc_req_ctrl
//  Brief    : Counts local events and launches them one at a time across a
//             clock boundary with a toggle request/acknowledge handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_cdc_req_ctrl
    import pulse_cdc_pkg::*;
#(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic             req_toggle,
    input  logic             ack_toggle,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             timeout_err,
    input  logic             clr_err
);

    localparam int unsigned      c_TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t               r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]     r_pending;
    logic                 r_req;
    logic                 r_overflow;
    logic                 r_timeout_err;

    logic w_ack_pulse;
    logic w_launch;
    logic w_drop;
    logic w_timer_expired;
    logic w_timeout;

    pulse_cdc_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk          (clk),
        .reset        (reset),
        .i_ack_toggle (ack_toggle),
        .o_ack_pulse  (w_ack_pulse)
    );

    assign w_launch = (r_state == IDLE) && (r_pending != '0);
    assign w_drop   = pulse_in && !w_launch && (r_pending == c_CNT_MAX);

    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
            assign w_timer_expired = (r_timer == c_TIMER_LAST);
        end else begin : g_no_timeout
            assign w_timer_expired = 1'b0;
        end
    endgenerate

    // An ack arriving on the expiry cycle completes the transfer normally.
    assign w_timeout = (r_state == WAIT_ACK) && !w_ack_pulse && w_timer_expired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else if (pulse_in && !w_launch && !w_drop) begin
            r_pending <= r_pending + 1'b1;
        end else if (!pulse_in && w_launch) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_req   <= ~r_req;
                        r_timer <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_ack_pulse || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Set beats clear so a coincident event is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overflow    <= w_drop    | (r_overflow    & ~clr_err);
            r_timeout_err <= w_timeout | (r_timeout_err & ~clr_err);
        end
    end

    assign req_toggle  = r_req;
    assign pending     = r_pending;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state == WAIT_ACK) || (r_pending != '0);

endmodule

`default_nettype wire

// File: tb/tb_pulse_cdc_req_ctrl.sv
// ============================================================================
//  Module   : tb_pulse_cdc_req_ctrl
//  Brief    : Self-checking bench for pulse_cdc_req_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pulse_cdc_req_ctrl;

    localparam int S     = 2;
    localparam int TO    = 16;
    localparam int MAX_A = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       tb_pulse = 1'b0, tb_ack = 1'b0, tb_clr = 1'b0;
    logic       req_toggle, busy, overflow, timeout_err;
    logic [3:0] pending;

    logic       b_pulse = 1'b0, b_ack = 1'b0, b_clr = 1'b0;
    logic       b_req, b_busy, b_ovf, b_to;
    logic [1:0] b_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state for DUT A
    int  m_pend, m_launch_cyc;
    bit  m_out, m_req, m_ovf, m_to;
    bit  m_hist[$];

    always #5 clk = ~clk;

    pulse_cdc_req_ctrl #(.CNT_W(4), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n), .pulse_in(tb_pulse), .req_toggle(req_toggle),
        .ack_toggle(tb_ack), .busy(busy), .pending(pending), .overflow(overflow),
        .timeout_err(timeout_err), .clr_err(tb_clr)
    );

    pulse_cdc_req_ctrl #(.CNT_W(2), .SYNC_STAGES(S), .TIMEOUT(TO)) dut_sat (
        .clk(clk), .reset(rst_n), .pulse_in(b_pulse), .req_toggle(b_req),
        .ack_toggle(b_ack), .busy(b_busy), .pending(b_pending), .overflow(b_ovf),
        .timeout_err(b_to), .clr_err(b_clr)
    );

    function automatic void model_reset();
        m_pend = 0; m_launch_cyc = 0; m_out = 0; m_req = 0; m_ovf = 0; m_to = 0;
        m_hist = {};
        for (int i = 0; i <= S; i++) m_hist.push_back(1'b0);
    endfunction

    // Transfer rules: ack seen S edges after it is first sampled; a launch
    // happens whenever nothing is outstanding and events are queued.
    function automatic void model_step();
        bit ack_seen, launch, ovf_set, to_set;
        ack_seen = m_hist[S-1] ^ m_hist[S];
        launch   = !m_out && (m_pend != 0);
        to_set   = 1'b0;
        ovf_set  = 1'b0;
        if (m_out) begin
            if (ack_seen) m_out = 1'b0;
            else if (TO != 0 && (cyc - m_launch_cyc) == TO) begin
                m_out = 1'b0; to_set = 1'b1;
            end
        end
        if (launch) begin
            m_req = !m_req; m_out = 1'b1; m_launch_cyc = cyc;
        end
        if (tb_pulse && !launch) begin
            if (m_pend == MAX_A) ovf_set = 1'b1;
            else m_pend++;
        end else if (!tb_pulse && launch) begin
            m_pend--;
        end
        m_ovf = ovf_set || (m_ovf && !tb_clr);
        m_to  = to_set  || (m_to  && !tb_clr);
        m_hist.push_front(tb_ack);
        void'(m_hist.pop_back());
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++; if (req_toggle !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", req_toggle); end
        checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if ({overflow, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, timeout_err}); end
        checks++; if ({b_req, b_busy, b_pending, b_ovf, b_to} !== 6'd0) begin errors++; $display("FAIL reset_sat_dut: got %b want 0", {b_req, b_busy, b_pending, b_ovf, b_to}); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if ({req_toggle, busy} !== 2'b00) begin errors++; $display("FAIL reset_release: got %b want 00", {req_toggle, busy}); end
    endtask

    task automatic test_single();
        logic r0;
        int   n;
        r0 = req_toggle;
        tb_pulse = 1'b1; tick(); tb_pulse = 1'b0;
        checks++; if (pending !== 4'd1 || req_toggle !== r0) begin errors++; $display("FAIL single_accept: pending %0d req %0b want 1 %0b", pending, req_toggle, r0); end
        tick();
        checks++; if (req_toggle !== ~r0 || busy !== 1'b1 || pending !== 4'd0) begin errors++; $display("FAIL single_launch: req %0b busy %0b pending %0d", req_toggle, busy, pending); end
        repeat (4) tick();
        n = 4;
        tb_ack = ~tb_ack;
        do begin tick(); n++; end while (busy === 1'b1 && n < 40);
        checks++; if (n != S + 5) begin errors++; $display("FAIL single_busy_fall: got %0d cycles want %0d", n, S + 5); end
        checks++; if (pending !== 4'd0 || req_toggle !== ~r0) begin errors++; $display("FAIL single_final: pending %0d req %0b", pending, req_toggle); end
    endtask

    task automatic test_back_to_back();
        int   flips, peak, last;
        logic prev;
        flips = 0; peak = 0; last = -1; prev = req_toggle;
        for (int i = 0; i < 60; i++) begin
            tb_pulse = (i < 5);
            tb_ack   = req_toggle;
            tick();
            if (int'(pending) > peak) peak = int'(pending);
            if (req_toggle !== prev) begin
                flips++;
                if (last >= 0) begin
                    checks++; if (i - last != S + 2) begin errors++; $display("FAIL burst_spacing: got %0d want %0d", i - last, S + 2); end
                end
                last = i; prev = req_toggle;
            end
        end
        tb_pulse = 1'b0;
        tb_ack   = req_toggle;
        checks++; if (flips != 5) begin errors++; $display("FAIL burst_flips: got %0d want 5", flips); end
        checks++; if (peak != 4) begin errors++; $display("FAIL burst_peak: got %0d want 4", peak); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle: busy %0b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic r0;
        r0 = req_toggle;
        tb_pulse = 1'b1; tick(); tick(); tb_pulse = 1'b0;
        checks++; if (req_toggle !== ~r0 || pending !== 4'd1) begin errors++; $display("FAIL to_launch: req %0b pending %0d", req_toggle, pending); end
        repeat (15) tick();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: err %0b busy %0b want 0 1", timeout_err, busy); end
        tick();
        checks++; if (timeout_err !== 1'b1 || req_toggle !== ~r0) begin errors++; $display("FAIL to_expire: err %0b req %0b want 1 %0b", timeout_err, req_toggle, ~r0); end
        tick();
        checks++; if (req_toggle !== r0 || pending !== 4'd0) begin errors++; $display("FAIL to_relaunch: req %0b pending %0d want %0b 0", req_toggle, pending, r0); end
        repeat (16) tick();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_second: busy %0b err %0b want 0 1", busy, timeout_err); end
        tb_ack = ~tb_ack;
        repeat (S + 3) tick();
        checks++; if (req_toggle !== r0 || busy !== 1'b0) begin errors++; $display("FAIL stray_ack: req %0b busy %0b want %0b 0", req_toggle, busy, r0); end
        tb_clr = 1'b1; tick(); tb_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b want 0", timeout_err); end
    endtask

    task automatic test_ack_timeout_race();
        logic r0;
        r0 = req_toggle;
        tb_pulse = 1'b1; tick(); tb_pulse = 1'b0;
        tick();
        checks++; if (req_toggle !== ~r0) begin errors++; $display("FAIL race_launch: req %0b want %0b", req_toggle, ~r0); end
        repeat (13) tick();
        tb_ack = ~tb_ack; tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL race_wait: busy %0b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL race_ack_wins: busy %0b err %0b want 0 0", busy, timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_after: err %0b want 0", timeout_err); end
    endtask

    task automatic test_saturation();
        b_pulse = 1'b1; repeat (6) tick(); b_pulse = 1'b0;
        checks++; if (b_pending !== 2'd3 || b_ovf !== 1'b1) begin errors++; $display("FAIL sat_stick: pending %0d ovf %0b want 3 1", b_pending, b_ovf); end
        b_pulse = 1'b1; b_clr = 1'b1; tick(); b_pulse = 1'b0; b_clr = 1'b0;
        checks++; if (b_ovf !== 1'b1 || b_pending !== 2'd3) begin errors++; $display("FAIL sat_set_wins: ovf %0b pending %0d want 1 3", b_ovf, b_pending); end
        b_clr = 1'b1; tick(); b_clr = 1'b0;
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL sat_clear: ovf %0b want 0", b_ovf); end
    endtask

    task automatic test_random();
        int pct;
        pct = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) pct = $urandom_range(0, 50);
            tb_pulse = ($urandom_range(0, 99) < pct);
            if ($urandom_range(0, 7) == 0) tb_ack = ~tb_ack;
            tb_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++; if (req_toggle !== m_req) begin errors++; $display("FAIL rand_req cyc %0d: got %0b want %0b", cyc, req_toggle, m_req); end
            checks++; if (pending !== 4'(m_pend)) begin errors++; $display("FAIL rand_pending cyc %0d: got %0d want %0d", cyc, pending, m_pend); end
            checks++; if (busy !== (m_out || m_pend != 0)) begin errors++; $display("FAIL rand_busy cyc %0d: got %0b", cyc, busy); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d: got %0b want %0b", cyc, overflow, m_ovf); end
            checks++; if (timeout_err !== m_to) begin errors++; $display("FAIL rand_to cyc %0d: got %0b want %0b", cyc, timeout_err, m_to); end
        end
        tb_pulse = 1'b0; tb_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 300) begin tb_ack = req_toggle; tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_drain: busy %0b want 0 after %0d cycles", busy, n); end
        tb_clr = 1'b1; tick(); tb_clr = 1'b0;
        tb_pulse = 1'b1; repeat (4) tick(); tb_pulse = 1'b0;
        checks++; if (pending !== 4'd3 || busy !== 1'b1) begin errors++; $display("FAIL mid_setup: pending %0d busy %0b want 3 1", pending, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({req_toggle, busy, pending, overflow, timeout_err} !== 8'd0) begin errors++; $display("FAIL mid_async_reset: got %b want 0", {req_toggle, busy, pending, overflow, timeout_err}); end
        tb_ack = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tb_pulse = 1'b1; tick(); tb_pulse = 1'b0;
        tick();
        checks++; if (req_toggle !== 1'b1) begin errors++; $display("FAIL mid_restart: req %0b want 1", req_toggle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_ack_timeout_race();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
